// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: column drive, row synchronisation, frame-level
// debounce and a single-cycle key_valid/key_value handshake towards the lock controller.
module keypad_scanner #(
    parameter int CLK_DIV        = 1000,
    parameter int DEBOUNCE_SCANS = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] row_in,
    output logic [3:0] col_out,
    output logic       key_valid,
    output logic [3:0] key_value,
    output logic       key_down,
    output logic       multi_key
);

    localparam int              DIV_W    = $clog2(CLK_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [7:0]      DEB_N    = 8'(DEBOUNCE_SCANS);

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        DEB_PRESS   = 2'd1,
        HELD        = 2'd2,
        DEB_RELEASE = 2'd3
    } state_t;

    logic [3:0]       row_meta;
    logic [3:0]       row_sync;
    logic [DIV_W-1:0] div;
    logic [1:0]       col;
    logic [15:0]      acc;
    logic [15:0]      cur_map;
    logic [15:0]      frame_map;
    logic [4:0]       key_count;
    logic             sample_edge;
    logic             frame_end;
    logic             is_none;
    logic             is_single;
    logic             is_multi;
    logic [3:0]       single_code;
    state_t           state;
    logic [3:0]       cand;
    logic [7:0]       cnt;

    function automatic logic [4:0] popcount16(input logic [15:0] m);
        logic [4:0] sum;
        sum = 5'd0;
        for (int i = 0; i < 16; i++) begin
            sum = sum + {4'd0, m[i]};
        end
        return sum;
    endfunction

    function automatic logic [3:0] lowest_index(input logic [15:0] m);
        logic [3:0] idx;
        idx = 4'd0;
        for (int i = 15; i >= 0; i--) begin
            if (m[i]) begin
                idx = 4'(i);
            end else begin
                idx = idx;
            end
        end
        return idx;
    endfunction

    // Bit index is {row, col}; table follows the printed keypad legend.
    function automatic logic [3:0] key_code(input logic [3:0] idx);
        logic [3:0] code;
        case (idx)
            4'd0:    code = 4'h1;
            4'd1:    code = 4'h2;
            4'd2:    code = 4'h3;
            4'd3:    code = 4'hA;
            4'd4:    code = 4'h4;
            4'd5:    code = 4'h5;
            4'd6:    code = 4'h6;
            4'd7:    code = 4'hB;
            4'd8:    code = 4'h7;
            4'd9:    code = 4'h8;
            4'd10:   code = 4'h9;
            4'd11:   code = 4'hC;
            4'd12:   code = 4'hE;
            4'd13:   code = 4'h0;
            4'd14:   code = 4'hF;
            4'd15:   code = 4'hD;
            default: code = 4'h0;
        endcase
        return code;
    endfunction

    // Frame classification, with the current column's rows folded in combinationally.
    always_comb begin
        cur_map = 16'd0;
        for (int r = 0; r < 4; r++) begin
            cur_map[{2'(r), col}] = ~row_sync[r];
        end
        sample_edge = (div == DIV_LAST);
        frame_end   = sample_edge && (col == 2'd3);
        frame_map   = acc | cur_map;
        key_count   = popcount16(frame_map);
        is_none     = (key_count == 5'd0);
        is_single   = (key_count == 5'd1);
        is_multi    = (key_count >= 5'd2);
        single_code = key_code(lowest_index(frame_map));
    end

    // Two-flop synchroniser for the asynchronous row inputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            row_meta <= 4'hF;
            row_sync <= 4'hF;
        end else begin
            row_meta <= row_in;
            row_sync <= row_meta;
        end
    end

    // Column slot divider, column drive and per-frame press accumulator.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div     <= '0;
            col     <= 2'd0;
            col_out <= 4'b1110;
            acc     <= 16'd0;
        end else if (sample_edge) begin
            div     <= '0;
            col     <= col + 2'd1;
            col_out <= ~(4'b0001 << (col + 2'd1));
            acc     <= frame_end ? 16'd0 : frame_map;
        end else begin
            div     <= div + 1'b1;
        end
    end

    // Debounce FSM, stepped once per frame; cnt never runs past DEB_N.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            cand      <= 4'h0;
            cnt       <= 8'd0;
            key_valid <= 1'b0;
            key_value <= 4'h0;
            key_down  <= 1'b0;
            multi_key <= 1'b0;
        end else begin
            key_valid <= 1'b0;
            if (frame_end) begin
                multi_key <= is_multi;
                case (state)
                    IDLE: begin
                        if (is_single) begin
                            cand <= single_code;
                            cnt  <= 8'd1;
                            if (DEB_N == 8'd1) begin
                                key_valid <= 1'b1;
                                key_value <= single_code;
                                key_down  <= 1'b1;
                                state     <= HELD;
                            end else begin
                                state <= DEB_PRESS;
                            end
                        end
                    end
                    DEB_PRESS: begin
                        if (is_single && (single_code == cand)) begin
                            cnt <= cnt + 8'd1;
                            if ((cnt + 8'd1) >= DEB_N) begin
                                key_valid <= 1'b1;
                                key_value <= cand;
                                key_down  <= 1'b1;
                                state     <= HELD;
                            end
                        end else begin
                            cnt   <= 8'd0;
                            state <= IDLE;
                        end
                    end
                    HELD: begin
                        if (is_none) begin
                            cnt <= 8'd1;
                            if (DEB_N == 8'd1) begin
                                key_down <= 1'b0;
                                state    <= IDLE;
                            end else begin
                                state <= DEB_RELEASE;
                            end
                        end
                    end
                    DEB_RELEASE: begin
                        if (is_none) begin
                            cnt <= cnt + 8'd1;
                            if ((cnt + 8'd1) >= DEB_N) begin
                                key_down <= 1'b0;
                                state    <= IDLE;
                            end
                        end else begin
                            state <= HELD;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_keypad_scanner.sv
// Self-checking bench for keypad_scanner: a keypad matrix model plus a scoreboard
// of expected key codes that is drained on every key_valid pulse.
module tb_keypad_scanner;

    localparam int CLK_DIV = 4;
    localparam int DEB     = 3;

    logic       clk;
    logic       reset;
    logic [3:0] row_in;
    logic [3:0] col_out;
    logic       key_valid;
    logic [3:0] key_value;
    logic       key_down;
    logic       multi_key;

    logic [15:0] keys;
    logic [3:0]  sb_q[$];
    int          nvec;
    int          nerr;
    int          pulses;

    keypad_scanner #(.CLK_DIV(CLK_DIV), .DEBOUNCE_SCANS(DEB)) dut (
        .clk       (clk),
        .reset     (reset),
        .row_in    (row_in),
        .col_out   (col_out),
        .key_valid (key_valid),
        .key_value (key_value),
        .key_down  (key_down),
        .multi_key (multi_key)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Keypad matrix: a pressed key pulls its row low while its column is driven low.
    always_comb begin
        for (int r = 0; r < 4; r++) begin
            row_in[r] = ~|(keys[r*4 +: 4] & ~col_out);
        end
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        nvec++;
        if (obs !== exp) begin
            nerr++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    // Each frame is 4*CLK_DIV cycles; callers start and end on a frame-aligned negedge.
    task automatic run_frames(input int n);
        repeat (n * 4 * CLK_DIV) @(posedge clk);
        @(negedge clk);
    endtask

    // Scoreboard drain: every pulse must match the oldest outstanding expected code.
    always @(negedge clk) begin
        if (!reset && key_valid) begin
            pulses++;
            if (sb_q.size() == 0) begin
                chk("unexpected_pulse", {12'd0, key_value}, 16'hFFFF);
            end else begin
                logic [3:0] exp_code;
                exp_code = sb_q.pop_front();
                chk("pulse_value", {12'd0, key_value}, {12'd0, exp_code});
            end
        end
    end

    initial begin
        int p0;
        nvec   = 0;
        nerr   = 0;
        pulses = 0;
        keys   = 16'd0;
        reset  = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (6) @(posedge clk);

        // 1: asynchronous reset mid-scan, then first column step
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        chk("rst_col_out", {12'd0, col_out}, 16'h000E);
        chk("rst_key_valid", {15'd0, key_valid}, 16'd0);
        chk("rst_key_value", {12'd0, key_value}, 16'd0);
        chk("rst_key_down", {15'd0, key_down}, 16'd0);
        chk("rst_multi_key", {15'd0, multi_key}, 16'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (CLK_DIV - 1) @(posedge clk);
        #1 chk("col_hold", {12'd0, col_out}, 16'h000E);
        @(posedge clk);
        #1 chk("col_step", {12'd0, col_out}, 16'h000D);
        repeat (3 * CLK_DIV) @(posedge clk);
        @(negedge clk);

        // 2: clean press of key 5 (row 1, col 1)
        keys = 16'd1 << 5;
        sb_q.push_back(4'h5);
        run_frames(2);
        chk("clean_no_early", {15'd0, key_valid}, 16'd0);
        run_frames(1);
        chk("clean_valid", {15'd0, key_valid}, 16'd1);
        chk("clean_value", {12'd0, key_value}, 16'h0005);
        chk("clean_down", {15'd0, key_down}, 16'd1);
        run_frames(3);
        keys = 16'd0;
        run_frames(2);
        chk("clean_down_hold", {15'd0, key_down}, 16'd1);
        run_frames(1);
        chk("clean_down_drop", {15'd0, key_down}, 16'd0);
        chk("clean_pulses", 16'(pulses), 16'd1);

        // 3: bounce on key 7 (row 2, col 0)
        p0 = pulses;
        keys = 16'd1 << 8;
        run_frames(2);
        keys = 16'd0;
        run_frames(1);
        chk("bounce_no_pulse", 16'(pulses), 16'(p0));
        keys = 16'd1 << 8;
        sb_q.push_back(4'h7);
        run_frames(3);
        chk("bounce_valid", {15'd0, key_valid}, 16'd1);
        keys = 16'd0;
        run_frames(3);
        chk("bounce_pulses", 16'(pulses), 16'(p0 + 1));

        // 4: keys 1 and 2 together, then key 2 released
        p0 = pulses;
        keys = 16'b11;
        run_frames(4);
        chk("multi_flag", {15'd0, multi_key}, 16'd1);
        chk("multi_no_pulse", 16'(pulses), 16'(p0));
        keys = 16'b01;
        sb_q.push_back(4'h1);
        run_frames(1);
        chk("multi_clear", {15'd0, multi_key}, 16'd0);
        run_frames(2);
        chk("multi_then_valid", {15'd0, key_valid}, 16'd1);
        keys = 16'd0;
        run_frames(3);

        // 5: hold # (row 3, col 2) then release with bounce
        p0 = pulses;
        keys = 16'd1 << 14;
        sb_q.push_back(4'hF);
        run_frames(20);
        chk("hold_one_pulse", 16'(pulses), 16'(p0 + 1));
        chk("hold_value", {12'd0, key_value}, 16'h000F);
        keys = 16'd0;
        run_frames(1);
        keys = 16'd1 << 14;
        run_frames(1);
        keys = 16'd0;
        run_frames(2);
        chk("release_down_hold", {15'd0, key_down}, 16'd1);
        run_frames(1);
        chk("release_down_drop", {15'd0, key_down}, 16'd0);
        chk("release_no_repulse", 16'(pulses), 16'(p0 + 1));

        // 6: reset during press debounce, then a fresh press of key 9
        p0 = pulses;
        keys = 16'd1 << 10;
        run_frames(2);
        reset = 1'b1;
        #1;
        chk("mid_rst_down", {15'd0, key_down}, 16'd0);
        chk("mid_rst_col", {12'd0, col_out}, 16'h000E);
        keys = 16'd0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        run_frames(4);
        chk("mid_rst_no_pulse", 16'(pulses), 16'(p0));
        keys = 16'd1 << 10;
        sb_q.push_back(4'h9);
        run_frames(3);
        chk("fresh_valid", {15'd0, key_valid}, 16'd1);
        chk("fresh_value", {12'd0, key_value}, 16'h0009);
        keys = 16'd0;
        run_frames(3);

        chk("sb_empty", 16'(sb_q.size()), 16'd0);
        chk("total_pulses", 16'(pulses), 16'd5);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/keypad_scanner.md
# keypad_scanner

- Drives a 4x4 matrix keypad one column at a time and samples its rows.
- Debounces presses and releases over whole scan frames.
- Emits exactly one single-cycle `key_valid` pulse with a 4-bit `key_value` per debounced press. This is the producer side of the `key_valid`/`key_value` interface that the lock controller consumes.
- Sits between the keypad pins and the lock controller.

## Interface
- `CLK_DIV`, default 1000: clk cycles per column slot. Must be ≥ 4.
- `DEBOUNCE_SCANS`, default 3: consecutive identical frames needed to accept a press or a release. Range 1..255.
- `clk`  in  1  system clock.
- `reset`  in  1  reset, asynchronous, active-high; clock clk.
- `row_in`  in  4  keypad rows, active-low (pulled up), asynchronous to clk.
- `col_out`  out  4  column drive, active-low, one-hot-zero.
- `key_valid`  out  1  one-cycle pulse per accepted key press.
- `key_value`  out  4  code of the last accepted key; stable between pulses.
- `key_down`  out  1  high while an accepted key is considered held.
- `multi_key`  out  1  high if the most recent completed frame had ≥ 2 keys pressed.

## Operation
- **Row synchronisation:** `row_in` passes through a 2-flop synchroniser before any use.
- **Column scan:**
  - Divider `div` counts 0..CLK_DIV-1.
  - At `div==CLK_DIV-1` the synchronised rows are sampled for the current column, then the column advances 0→1→2→3→0.
  - `col_out` = ~(1<<col).
- **Frame:**
  - One frame is columns 0..3, i.e. 4*CLK_DIV cycles.
  - At the column-3 sample edge the frame is classified as NONE (0 keys), SINGLE(K), or MULTI (≥ 2 keys).
  - The column-3 sample is included combinationally in that classification.
  - The frame accumulator clears for the next frame.
- **Key map:**
  - Codes are listed as row r (0..3) by column c (0..3).
  - Row 0: 1, 2, 3, A.
  - Row 1: 4, 5, 6, B.
  - Row 2: 7, 8, 9, C.
  - Row 3: E (`*`), 0, F (`#`), D.
- **FSM:** evaluated only at frame-end edges. It holds a candidate code `cand` and an 8-bit counter `cnt`.
  - **IDLE:**
    - SINGLE(K): `cand`=K, `cnt`=1, go to DEB_PRESS. If DEBOUNCE_SCANS==1, accept immediately (see below) and go to HELD.
    - NONE or MULTI: stay in IDLE.
  - **DEB_PRESS:**
    - SINGLE(`cand`): `cnt`++.
    - When `cnt` reaches DEBOUNCE_SCANS, accept: pulse `key_valid`, `key_value`=`cand`, go to HELD.
    - Any other frame (NONE, MULTI, or a different single key): go to IDLE with no pulse.
  - **HELD:**
    - `key_down`=1.
    - NONE: `cnt`=1, go to DEB_RELEASE. If DEBOUNCE_SCANS==1, go directly to IDLE.
    - Any non-NONE frame, including MULTI or a different key: stay in HELD. No rollover and no autorepeat.
  - **DEB_RELEASE:**
    - `key_down` stays 1.
    - NONE: `cnt`++. When `cnt` reaches DEBOUNCE_SCANS, go to IDLE and `key_down`=0.
    - Any non-NONE frame: go back to HELD. No pulse.
- **`multi_key`:** updated at every frame end, in all states. It is a classification flag only.

## Timing
- **Reset values:**
  - `col_out`=4'b1110, `div`=0, col=0.
  - `key_valid`=0, `key_value`=0, `key_down`=0, `multi_key`=0.
  - FSM in IDLE, `cnt`=0, synchroniser flops=1.
- `key_valid` is registered. It is high for exactly one clk cycle, the cycle following the accepting frame-end edge.
- `key_value` updates on that same edge and holds until the next accept.
- **Press latency:** a key stable from the start of frame n is accepted at the end of frame n+DEBOUNCE_SCANS-1.
- **Release latency:** DEBOUNCE_SCANS NONE frames after the release.
- **Row settling:** the row sample for a column is taken CLK_DIV-1 cycles after `col_out` changes. This covers the 2-cycle synchroniser latency because CLK_DIV ≥ 4.
- **Counter saturation:** `cnt` never exceeds DEBOUNCE_SCANS.
- **Reset mid-operation:** an asynchronous return to the reset values. No `key_valid` may be emitted because of a partially debounced press.

## Test plan
1. **Reset:** assert `reset` mid-scan → all outputs at reset values and `col_out`=1110 within the same cycle. After release, `col_out` steps 1110→1101 after CLK_DIV cycles.
2. **Clean press:** CLK_DIV=4, DEBOUNCE_SCANS=3. Hold row 1/col 1 for 6 frames, then release.
   - Exactly one `key_valid` pulse, with `key_value`=4'h5, at the end of frame 3.
   - `key_down` drops 3 frames after release.
3. **Bounce:** key 7 for 2 frames, NONE for 1 frame, key 7 for 3 frames.
   - No pulse during the first run.
   - One pulse with `key_value`=4'h7 at the end of the second run.
4. **Multi-key:** keys 1 and 2 together for 4 frames.
   - `multi_key`=1 and no `key_valid`.
   - Then release key 2 → `multi_key`=0, then one pulse with `key_value`=4'h1 after 3 frames.
5. **Hold and release bounce:**
   - Hold `#` for 20 frames → exactly one pulse, `key_value`=4'hF.
   - During release, NONE, `#`, NONE, NONE, NONE → no second pulse; `key_down` falls after the last 3 NONE frames.
6. **Reset during press debounce:**
   - Assert reset in DEB_PRESS after 2 matching frames → no pulse ever for that press.
   - A fresh 3-frame press afterwards produces one pulse.
